// File: rtl/victim_writeback_if.sv
// Eviction, memory-write and snoop signals between the victim buffer controller and the
// victim writeback block.
interface victim_writeback_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 64
);
  logic                     evict_req;
  logic                     evict_ready;
  logic [ADDR_W+DATA_W+1:0] victimEv_data;
  logic                     roll;
  logic                     evict_done;
  logic                     mem_wr_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_wr_ack;
  logic [ADDR_W-1:0]        snoop_addr;
  logic                     snoop_hit;
  logic                     q_empty;
  logic                     q_full;

  modport slave (
    input  evict_req, victimEv_data, mem_wr_ack, snoop_addr,
    output evict_ready, roll, evict_done, mem_wr_req, mem_addr, mem_wdata, snoop_hit,
           q_empty, q_full
  );

  modport master (
    output evict_req, victimEv_data, mem_wr_ack, snoop_addr,
    input  evict_ready, roll, evict_done, mem_wr_req, mem_addr, mem_wdata, snoop_hit,
           q_empty, q_full
  );
endinterface

// File: rtl/victim_writeback.sv
// Queues dirty lines evicted from the victim buffer and writes them back to memory in order;
// clean or invalid lines are dropped. Snoops queued addresses for read-after-evict hazards.
module victim_writeback #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 64
) (
  input logic               clk,
  input logic               rst,
  victim_writeback_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned VBit = ADDR_W + DATA_W + 1;
  localparam int unsigned DBit = ADDR_W + DATA_W;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              roll_q, roll_d;
  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic q_full, q_empty, ready, accept, push, pop, hit;

  always_comb begin
    q_full  = (count_q == FullCnt);
    q_empty = (count_q == '0);
    // Blocking accepts during roll lets the buffer advance its pointer first.
    ready   = !q_full && !roll_q;
    accept  = bus.evict_req && ready;
    push    = accept && bus.victimEv_data[VBit] && bus.victimEv_data[DBit];
    roll_d  = accept;

    state_d     = state_q;
    req_d       = req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = data_q[head_q];
          req_d       = 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (bus.mem_wr_ack) begin
          pop     = 1'b1;
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    head_d  = head_q + PtrW'(pop);
    tail_d  = tail_q + PtrW'(push);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Entry i is occupied when its distance from the head is below the count.
  always_comb begin
    logic [PtrW-1:0] rel;
    rel = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PtrW'(i) - head_q;
      if (({1'b0, rel} < count_q) && (addr_q[i] == bus.snoop_addr)) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.victimEv_data[DBit-1:DATA_W];
      data_q[tail_q] <= bus.victimEv_data[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      roll_q      <= 1'b0;
      state_q     <= StIdle;
      req_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      roll_q      <= roll_d;
      state_q     <= state_d;
      req_q       <= req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.evict_ready = ready;
  assign bus.roll        = roll_q;
  assign bus.evict_done  = roll_q;
  assign bus.mem_wr_req  = req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.snoop_hit   = hit;
  assign bus.q_empty     = q_empty;
  assign bus.q_full      = q_full;
endmodule
